// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron output monitors.
//   - default widths for the spike-rate / ISI monitor
//   - rate_state_t: window state machine encoding
//   - sat_inc(): width-generic saturating increment (values up to 32 bits)
package lif_pkg;

    localparam int LIF_CNT_W = 8;
    localparam int LIF_WIN_W = 16;
    localparam int LIF_ISI_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rate_state_t;

    // Returns val+1, clamped to the all-ones value of a 'width'-bit counter.
    // Callers cast the result back down to their own counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_v) ? max_v : (val + 32'd1);
    endfunction

endpackage

// File: rtl/spike_edge_det.sv
// Rising-edge detector for the neuron spike line.
// The delayed copy tracks the spike line every cycle (no enable), so an
// enable/clear sequence can never manufacture a false edge.
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   spike_i in  spike level from the LIF neuron
//   edge_o  out high for the first cycle spike_i is high
module spike_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic spike_i,
    output logic edge_o
);

    logic spike_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_d_q <= 1'b0;
        end else begin
            spike_d_q <= spike_i;
        end
    end

    assign edge_o = spike_i & ~spike_d_q;

endmodule

// File: rtl/spike_rate_window.sv
// Spike-rate and inter-spike-interval monitor for the LIF neuron core.
// Counts spike edges over a programmable window and measures the cycles
// between the two most recent edges; both results are registered with a
// one-cycle valid strobe in the cycle the data changes.
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   ena        in  enable; low freezes all counters and the state machine
//   spike_in   in  spike level from the neuron (may stay high >1 cycle)
//   clear      in  synchronous restart, overrides ena
//   win_len    in  window length in cycles, 0 = no windowing
//   rate_out   out spike count of the last completed window (saturating)
//   rate_valid out one-cycle strobe with each new rate_out
//   isi_out    out cycles between the two most recent edges (saturating)
//   isi_valid  out one-cycle strobe with each new isi_out
//   win_active out high while the window state machine is in RUN
module spike_rate_window
    import lif_pkg::*;
#(
    parameter int CNT_W = LIF_CNT_W,
    parameter int WIN_W = LIF_WIN_W,
    parameter int ISI_W = LIF_ISI_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike_in,
    input  logic             clear,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic [ISI_W-1:0] isi_out,
    output logic             isi_valid,
    output logic             win_active
);

    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
    localparam logic [ISI_W-1:0] ISI_ONE = ISI_W'(1);

    rate_state_t      state_q, state_d;
    logic [WIN_W-1:0] len_q, len_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] spk_cnt_q, spk_cnt_d;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic             rate_vld_q, rate_vld_d;
    logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
    logic             seen_q, seen_d;
    logic [ISI_W-1:0] isi_q, isi_d;
    logic             isi_vld_q, isi_vld_d;

    logic             spike_edge;
    logic [CNT_W-1:0] spk_inc;
    logic [ISI_W-1:0] isi_inc;

    spike_edge_det u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .spike_i (spike_in),
        .edge_o  (spike_edge)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        win_cnt_d  = win_cnt_q;
        spk_cnt_d  = spk_cnt_q;
        rate_d     = rate_q;
        rate_vld_d = 1'b0;
        isi_cnt_d  = isi_cnt_q;
        seen_d     = seen_q;
        isi_d      = isi_q;
        isi_vld_d  = 1'b0;
        spk_inc    = CNT_W'(sat_inc(32'(spk_cnt_q), CNT_W));
        isi_inc    = ISI_W'(sat_inc(32'(isi_cnt_q), ISI_W));

        if (clear) begin
            state_d   = IDLE;
            len_d     = '0;
            win_cnt_d = '0;
            spk_cnt_d = '0;
            rate_d    = '0;
            isi_cnt_d = '0;
            seen_d    = 1'b0;
            isi_d     = '0;
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    if (win_len != '0) begin
                        len_d     = win_len;
                        win_cnt_d = '0;
                        spk_cnt_d = '0;
                        state_d   = RUN;
                    end
                end
                RUN: begin
                    if (win_cnt_q == len_q - WIN_ONE) begin
                        // An edge on the closing cycle belongs to this window.
                        rate_d     = spike_edge ? spk_inc : spk_cnt_q;
                        rate_vld_d = 1'b1;
                        spk_cnt_d  = '0;
                        win_cnt_d  = '0;
                        // Window length is only resampled here.
                        len_d      = win_len;
                        if (win_len == '0) begin
                            state_d = IDLE;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_ONE;
                        if (spike_edge) begin
                            spk_cnt_d = spk_inc;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // Interval timer runs independently of the window state.
            if (spike_edge) begin
                if (seen_q) begin
                    isi_d     = isi_cnt_q;
                    isi_vld_d = 1'b1;
                end
                isi_cnt_d = ISI_ONE;
                seen_d    = 1'b1;
            end else if (seen_q) begin
                isi_cnt_d = isi_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            win_cnt_q  <= '0;
            spk_cnt_q  <= '0;
            rate_q     <= '0;
            rate_vld_q <= 1'b0;
            isi_cnt_q  <= '0;
            seen_q     <= 1'b0;
            isi_q      <= '0;
            isi_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            win_cnt_q  <= win_cnt_d;
            spk_cnt_q  <= spk_cnt_d;
            rate_q     <= rate_d;
            rate_vld_q <= rate_vld_d;
            isi_cnt_q  <= isi_cnt_d;
            seen_q     <= seen_d;
            isi_q      <= isi_d;
            isi_vld_q  <= isi_vld_d;
        end
    end

    assign rate_out   = rate_q;
    assign rate_valid = rate_vld_q;
    assign isi_out    = isi_q;
    assign isi_valid  = isi_vld_q;
    assign win_active = (state_q == RUN);

endmodule

// File: tb/tb_spike_rate_window.sv
// Bench for spike_rate_window. The reference model works on timestamps:
// each enabled cycle has an index, spikes are recorded as edge times, a
// window is [start, start+len-1] in enabled-cycle time, and an ISI is the
// difference of two edge timestamps clamped to 255.
module tb_spike_rate_window;

  localparam int CNT_W = 8;
  localparam int WIN_W = 16;
  localparam int ISI_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             spike_in;
  logic             clear;
  logic [WIN_W-1:0] win_len;
  logic [CNT_W-1:0] rate_out;
  logic             rate_valid;
  logic [ISI_W-1:0] isi_out;
  logic             isi_valid;
  logic             win_active;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  spike_rate_window #(
    .CNT_W (CNT_W),
    .WIN_W (WIN_W),
    .ISI_W (ISI_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .spike_in   (spike_in),
    .clear      (clear),
    .win_len    (win_len),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .isi_out    (isi_out),
    .isi_valid  (isi_valid),
    .win_active (win_active)
  );

  // ---------------- reference model ----------------
  bit     m_prev;
  bit     m_run;
  bit     m_rv;
  bit     m_iv;
  int     m_rate;
  int     m_isi;
  longint m_etime;
  longint m_last;
  longint m_wstart;
  longint m_wlen;
  longint edge_q[$];

  // scoreboard queues of expected results
  logic [CNT_W-1:0] rate_exp_q[$];
  logic [ISI_W-1:0] isi_exp_q[$];

  // observation bookkeeping for directed checks
  int n_rate_v;
  int n_isi_v;
  int last_rate;
  int isi_seen[$];

  task automatic model_reset();
    m_prev  = 1'b0;
    m_run   = 1'b0;
    m_rv    = 1'b0;
    m_iv    = 1'b0;
    m_rate  = 0;
    m_isi   = 0;
    m_etime = 0;
    m_last  = -1;
    m_wstart = 0;
    m_wlen  = 0;
    edge_q.delete();
    rate_exp_q.delete();
    isi_exp_q.delete();
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit     e;
    int     n;
    longint d;
    e = spike_in && !m_prev;
    m_prev = spike_in;
    m_rv = 1'b0;
    m_iv = 1'b0;
    if (clear) begin
      m_run  = 1'b0;
      m_rate = 0;
      m_isi  = 0;
      m_last = -1;
      edge_q.delete();
    end else if (ena) begin
      if (e) begin
        edge_q.push_back(m_etime);
        if (m_last >= 0) begin
          d = m_etime - m_last;
          m_isi = (d > 255) ? 255 : int'(d);
          m_iv = 1'b1;
          isi_exp_q.push_back(ISI_W'(m_isi));
        end
        m_last = m_etime;
      end
      if (!m_run) begin
        if (win_len != 0) begin
          m_run = 1'b1;
          m_wstart = m_etime + 1;
          m_wlen = longint'(win_len);
          edge_q.delete();
        end
      end else if (m_etime == m_wstart + m_wlen - 1) begin
        n = 0;
        foreach (edge_q[i]) if (edge_q[i] >= m_wstart && edge_q[i] <= m_etime) n++;
        m_rate = (n > 255) ? 255 : n;
        m_rv = 1'b1;
        rate_exp_q.push_back(CNT_W'(m_rate));
        edge_q.delete();
        if (win_len == 0) begin
          m_run = 1'b0;
        end else begin
          m_wstart = m_etime + 1;
          m_wlen = longint'(win_len);
        end
      end
      m_etime++;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("rate_valid", 32'(rate_valid), 32'(m_rv));
    chk("isi_valid", 32'(isi_valid), 32'(m_iv));
    chk("rate_out", 32'(rate_out), 32'(m_rate));
    chk("isi_out", 32'(isi_out), 32'(m_isi));
    chk("win_active", 32'(win_active), 32'(m_run));
    if (rate_valid === 1'b1) begin
      n_rate_v++;
      last_rate = int'(rate_out);
      chk("rate_sb_depth", 32'(rate_exp_q.size()), 32'd1);
      if (rate_exp_q.size() > 0) chk("rate_sb", 32'(rate_out), 32'(rate_exp_q.pop_front()));
    end
    if (isi_valid === 1'b1) begin
      n_isi_v++;
      isi_seen.push_back(int'(isi_out));
      chk("isi_sb_depth", 32'(isi_exp_q.size()), 32'd1);
      if (isi_exp_q.size() > 0) chk("isi_sb", 32'(isi_out), 32'(isi_exp_q.pop_front()));
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_clear();
    spike_in = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int ticks;

    // reset
    rst_n = 1'b0;
    ena = 1'b0;
    spike_in = 1'b0;
    clear = 1'b0;
    win_len = '0;
    n_rate_v = 0;
    n_isi_v = 0;
    last_rate = -1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // window of 10 with spikes at window cycles 2, 5, 9, then an empty window
    win_len = 16'd10;
    ena = 1'b1;
    tick();
    n_rate_v = 0;
    for (int w = 0; w < 10; w++) begin
      spike_in = (w == 2 || w == 5 || w == 9);
      tick();
    end
    spike_in = 1'b0;
    chk("win10_rate", 32'(last_rate), 32'd3);
    chk("win10_count", 32'(n_rate_v), 32'd1);
    for (int w = 0; w < 10; w++) tick();
    chk("win10_empty_rate", 32'(last_rate), 32'd0);
    chk("win10_empty_count", 32'(n_rate_v), 32'd2);

    // clear in the middle of a window
    for (int w = 0; w < 4; w++) begin
      spike_in = (w == 1);
      tick();
    end
    n_rate_v = 0;
    n_isi_v = 0;
    do_clear();
    chk("clear_rate_out", 32'(rate_out), 32'd0);
    chk("clear_isi_out", 32'(isi_out), 32'd0);
    chk("clear_active", 32'(win_active), 32'd0);
    chk("clear_strobes", 32'(n_rate_v + n_isi_v), 32'd0);

    // level held high for 4 cycles is a single spike
    tick();
    n_isi_v = 0;
    for (int w = 0; w < 10; w++) begin
      spike_in = (w >= 3 && w <= 6);
      tick();
    end
    spike_in = 1'b0;
    chk("held_rate", 32'(last_rate), 32'd1);
    chk("held_no_isi", 32'(n_isi_v), 32'd0);

    // ISI: edges at relative cycles 100, 137, 500
    do_clear();
    win_len = '0;
    isi_seen.delete();
    for (int k = 0; k < 506; k++) begin
      spike_in = (k == 100 || k == 137 || k == 500);
      tick();
    end
    spike_in = 1'b0;
    chk("isi_count", 32'(isi_seen.size()), 32'd2);
    if (isi_seen.size() >= 2) begin
      chk("isi_37", 32'(isi_seen[0]), 32'd37);
      chk("isi_sat", 32'(isi_seen[1]), 32'd255);
    end

    // 8-cycle window, alternating pulses, edge on the last window cycle
    do_clear();
    win_len = 16'd8;
    tick();
    n_rate_v = 0;
    for (int w = 0; w < 8; w++) begin
      spike_in = (w % 2 == 1);
      if (w == 7) win_len = 16'd1;
      tick();
    end
    chk("alt_rate", 32'(last_rate), 32'd4);
    chk("alt_count", 32'(n_rate_v), 32'd1);

    // win_len = 1: a result every cycle
    n_rate_v = 0;
    for (int k = 0; k < 10; k++) begin
      spike_in = (k % 3 == 0);
      tick();
    end
    chk("len1_count", 32'(n_rate_v), 32'd10);

    // long window with 300 edges saturates the count
    win_len = 16'd600;
    spike_in = 1'b0;
    tick();
    for (int k = 0; k < 600; k++) begin
      spike_in = (k % 2 == 1);
      tick();
    end
    spike_in = 1'b0;
    chk("rate_sat", 32'(last_rate), 32'd255);

    // window length change mid-window, then back to IDLE via win_len = 0
    do_clear();
    win_len = 16'd10;
    tick();
    ticks = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      ticks++;
      if (ticks == 4) win_len = 16'd3;
      if (rate_valid === 1'b1) break;
    end
    chk("len_change_first", 32'(ticks), 32'd10);
    ticks = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      ticks++;
      if (rate_valid === 1'b1) break;
    end
    chk("len_change_next", 32'(ticks), 32'd3);
    win_len = '0;
    ticks = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      ticks++;
      if (win_active !== 1'b1) break;
    end
    chk("len0_ticks", 32'(ticks), 32'd3);
    chk("len0_idle", 32'(win_active), 32'd0);

    // enable dropped for 5 cycles with a spike inside
    win_len = 16'd6;
    tick();
    ticks = 0;
    repeat (2) begin
      tick();
      ticks++;
    end
    ena = 1'b0;
    for (int k = 0; k < 5; k++) begin
      spike_in = (k == 2);
      tick();
      ticks++;
    end
    spike_in = 1'b0;
    ena = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      ticks++;
      if (rate_valid === 1'b1) break;
    end
    chk("ena_late_ticks", 32'(ticks), 32'd11);
    chk("ena_spike_ignored", 32'(last_rate), 32'd0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      ena = ($urandom_range(0, 9) != 0);
      spike_in = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) win_len = WIN_W'($urandom_range(0, 12));
      tick();
    end
    clear = 1'b0;

    // asynchronous reset mid-operation
    ena = 1'b1;
    win_len = 16'd5;
    for (int k = 0; k < 12; k++) begin
      spike_in = (k % 4 == 1);
      tick();
    end
    spike_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      spike_in = ($urandom_range(0, 2) == 0);
      tick();
    end

    chk("rate_sb_drained", 32'(rate_exp_q.size()), 32'd0);
    chk("isi_sb_drained", 32'(isi_exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
